// File: rtl/pht_update_ctrl.sv
// PHT update controller: sweeps every entry to INIT_STATE after reset, then turns
// branch resolutions into 2-bit counter writes queued onto w_ibus_o. Gshare indexing: `PHT_GSHARE_EN.
module pht_update_ctrl #(
  parameter int               ADDR_W     = 10,
  parameter int               STATE_W    = 2,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [STATE_W-1:0] INIT_STATE = 2'b01
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        upd_valid_i,
  output logic                        upd_ready_o,
  input  logic [31:0]                 upd_pc_i,
  input  logic [ADDR_W-1:0]           upd_ghr_i,
  input  logic                        upd_taken_i,
  input  logic [STATE_W-1:0]          upd_old_state_i,
  output logic                        init_done_o,
  output logic [ADDR_W+STATE_W:0]     w_ibus_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + STATE_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_W-1:0]         sweep_reg;
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+STATE_W:0]   w_ibus_reg;

  logic [ADDR_W-1:0]         upd_idx;
  logic [STATE_W-1:0]        new_state;
  logic                      fifo_empty, fifo_full;
  logic                      accept, push, pop;
  logic                      unused_bits;

`ifdef PHT_GSHARE_EN
  assign upd_idx = upd_pc_i[ADDR_W+1:2] ^ upd_ghr_i;
`else
  assign upd_idx = upd_pc_i[ADDR_W+1:2];
`endif
  assign unused_bits = ^{upd_ghr_i, upd_pc_i[31:ADDR_W+2], upd_pc_i[1:0]};

  // Saturating 2-bit counter step.
  always_comb begin
    new_state = upd_old_state_i;
    if (upd_taken_i && (upd_old_state_i != '1))
      new_state = upd_old_state_i + 1'b1;
    else if (!upd_taken_i && (upd_old_state_i != '0))
      new_state = upd_old_state_i - 1'b1;
  end

  // Same low bits with differing MSB means the write pointer has lapped the read pointer.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                      (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);

  assign accept = upd_valid_i && upd_ready_o;
  assign push   = accept && (new_state != upd_old_state_i);
  assign pop    = (state_reg == ST_RUN) && !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_INIT;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if ((state_reg == ST_INIT) && (&sweep_reg))
      state_next = ST_RUN;
  end

  // Output logic
  always_comb begin
    upd_ready_o = 1'b0;
    init_done_o = 1'b0;
    if (state_reg == ST_RUN) begin
      upd_ready_o = !fifo_full;
      init_done_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   sweep_reg <= '0;
    else if (state_reg == ST_INIT) sweep_reg <= sweep_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-2:0]] <= {upd_idx, new_state};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                    w_ibus_reg <= '0;
    else if (state_reg == ST_INIT) w_ibus_reg <= {1'b1, sweep_reg, INIT_STATE};
    else if (pop)                  w_ibus_reg <= {1'b1, fifo_mem[rd_ptr_reg[PTR_W-2:0]]};
    else                           w_ibus_reg <= '0;
  end

  assign w_ibus_o = w_ibus_reg;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Bench for pht_update_ctrl (ADDR_W=4, FIFO_DEPTH=2): queue-level reference model
// checked every cycle, plus directed reports with literal expected writes.
module tb_pht_update_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 2;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_pc = '0;
  logic [AW-1:0] upd_ghr = '0;
  logic        upd_taken = 1'b0;
  logic [1:0]  upd_old = '0;
  logic        init_done;
  logic [6:0]  w_ibus;

  int checks = 0;
  int errors = 0;

  pht_update_ctrl #(.ADDR_W(AW), .STATE_W(2), .FIFO_DEPTH(DEPTH), .INIT_STATE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
    .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
    .upd_old_state_i(upd_old), .init_done_o(init_done), .w_ibus_o(w_ibus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [5:0] pend [$];
  int   m_sweep = 0;
  bit   m_armed = 0;
  logic [6:0] exp_bus = '0;
  logic exp_ready = 1'b0;
  logic exp_done = 1'b0;

  function automatic logic [5:0] model_entry(logic [31:0] pc, logic [AW-1:0] ghr,
                                             logic taken, logic [1:0] old);
    int o, n;
    logic [AW-1:0] idx;
    o = old;
    n = taken ? ((o < 3) ? o + 1 : 3) : ((o > 0) ? o - 1 : 0);
`ifdef PHT_GSHARE_EN
    idx = pc[5:2] ^ ghr;
`else
    idx = pc[5:2];
`endif
    return {idx, 2'(n)};
  endfunction

  always @(posedge clk) begin
    bit rdy_now;
    logic [5:0] e;
    if (!rst_n) begin
      pend.delete();
      m_sweep = 0;
      exp_bus = '0;
      m_armed = 1;
    end else if (m_armed) begin
      rdy_now = (m_sweep == N) && (pend.size() < DEPTH);
      if (m_sweep < N) begin
        exp_bus = {1'b1, 4'(m_sweep), 2'b01};
        m_sweep++;
      end else begin
        if (pend.size() > 0) exp_bus = {1'b1, pend.pop_front()};
        else                 exp_bus = '0;
        if (upd_valid && rdy_now) begin
          e = model_entry(upd_pc, upd_ghr, upd_taken, upd_old);
          $display("report pc=%h ghr=%h taken=%0d old=%0d -> idx=%0d new=%0d",
                   upd_pc, upd_ghr, upd_taken, upd_old, e[5:2], e[1:0]);
          if (e[1:0] != upd_old) pend.push_back(e);
        end
      end
    end
    exp_done  = (m_sweep == N);
    exp_ready = exp_done && (pend.size() < DEPTH);
  end

  // Compare process: every cycle once a reset has been seen.
  always @(negedge clk) begin
    if (m_armed) begin
      checks += 3;
      if (w_ibus !== exp_bus) begin
        errors++;
        $display("FAIL model_bus t=%0t got=%b want=%b", $time, w_ibus, exp_bus);
      end
      if (upd_ready !== exp_ready) begin
        errors++;
        $display("FAIL model_ready t=%0t got=%b want=%b", $time, upd_ready, exp_ready);
      end
      if (init_done !== exp_done) begin
        errors++;
        $display("FAIL model_done t=%0t got=%b want=%b", $time, init_done, exp_done);
      end
      if (init_done && w_ibus[6])
        $display("write waddr=%0d wdata=%0d", w_ibus[5:2], w_ibus[1:0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [AW-1:0] ghr,
                       input logic taken, input logic [1:0] old);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = ghr; upd_taken = taken; upd_old = old;
  endtask

  // Release reset and follow a full sweep; expects rst_n low on entry.
  task automatic do_sweep();
    int n;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("sweep_first", w_ibus, 7'b1_0000_01);
    chk("sweep_ready_low", {6'd0, upd_ready}, 7'd0);
    n = 1;
    while (!init_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_cycles", 7'(n), 7'd16);
    chk("sweep_last", w_ibus, 7'b1_1111_01);
    chk("run_ready", {6'd0, upd_ready}, 7'd1);
  endtask

  typedef struct {logic [31:0] pc; logic taken; logic [1:0] old; logic [6:0] want;} vec_t;
  vec_t tbl [6];
  logic [6:0] gs_want;

  initial begin
    tbl[0] = '{32'h00, 1'b1, 2'd0, 7'b1_0000_01};
    tbl[1] = '{32'h04, 1'b1, 2'd1, 7'b1_0001_10};
    tbl[2] = '{32'h08, 1'b0, 2'd3, 7'b1_0010_10};
    tbl[3] = '{32'h0C, 1'b0, 2'd2, 7'b1_0011_01};
    tbl[4] = '{32'h10, 1'b1, 2'd2, 7'b1_0100_11};
    tbl[5] = '{32'h00, 1'b0, 2'd1, 7'b1_0000_00};
`ifdef PHT_GSHARE_EN
    gs_want = 7'b1_0100_10;
`else
    gs_want = 7'b1_0111_10;
`endif

    repeat (3) @(negedge clk);
    chk("reset_bus", w_ibus, 7'd0);
    chk("reset_ready_done", {5'd0, upd_ready, init_done}, 7'd0);

    // Reset mid-sweep, then a complete sweep from 0.
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    do_sweep();

    // Single taken report: weakly not-taken -> weakly taken at idx 7.
    @(negedge clk) drive(32'h1C, 4'h0, 1'b1, 2'd1);
    @(negedge clk) upd_valid = 1'b0;
    chk("t2_latency_idle", w_ibus, 7'd0);
    @(negedge clk);
    chk("t2_write", w_ibus, 7'b1_0111_10);
    @(negedge clk);
    chk("t2_we_drop", w_ibus, 7'd0);

    // Saturated reports: accepted, never written.
    @(negedge clk) drive(32'h20, 4'h0, 1'b1, 2'd3);
    @(negedge clk) drive(32'h24, 4'h0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) upd_valid = 1'b0;
      chk("t3_no_we", {6'd0, w_ibus[6]}, 7'd0);
    end

    // Six back-to-back reports, writes in order two cycles behind each report.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 2) chk("t4_order", w_ibus, tbl[k-2].want);
      if (k < 6) begin
        chk("t4_ready_held", {6'd0, upd_ready}, 7'd1);
        drive(tbl[k].pc, 4'h0, tbl[k].taken, tbl[k].old);
      end else begin
        upd_valid = 1'b0;
      end
    end

    // Index with history folded in (only changes the index when gshare is built in).
    @(negedge clk) drive(32'h1C, 4'h3, 1'b1, 2'd1);
    @(negedge clk) upd_valid = 1'b0;
    @(negedge clk);
    chk("t6_gshare_idx", w_ibus, gs_want);

    // Reset with writes still queued: queue dropped, sweep restarts.
    @(negedge clk) drive(32'h30, 4'h5, 1'b1, 2'd0);
    @(negedge clk) drive(32'h34, 4'h6, 1'b0, 2'd3);
    @(negedge clk) begin upd_valid = 1'b0; rst_n = 1'b0; end
    @(negedge clk);
    chk("t6_reset_bus", w_ibus, 7'd0);
    chk("t6_reset_ready", {6'd0, upd_ready}, 7'd0);
    do_sweep();
    repeat (3) @(negedge clk);
    chk("t6_no_stale", w_ibus, 7'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
